wb_stage_buf: RTL
=================

Name: wb_stage_buf

Overview:
Parametrised successor to the JOF32 write-back stage, placed between the MEM stage and the register-file write port.
- Selects among four result sources and performs load byte/half extraction with sign or zero extension.
- Buffers results in a 2-entry skid buffer with a valid/ready handshake toward the register file.
- Exposes a forwarding query port over pending entries and counts retired results.

Parameters:
DATA_W, 32, datapath width; multiple of 8, 32 or 64.
ADDR_W, 4, register address width.
CNT_W, 32, retire counter width.
ZERO_REG_WR, 1, 1 = writes to address 0 allowed; 0 = suppressed (wr_en forced 0 at capture).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  upstream beat valid.
in_ready  out  1  buffer can accept a beat.
result_alu  in  DATA_W  ALU result.
result_mem  in  DATA_W  raw memory read word.
result_link  in  DATA_W  return address.
result_imm  in  DATA_W  immediate value.
sel_wb  in  2  source select: 0 ALU, 1 MEM, 2 LINK, 3 IMM.
load_size  in  2  load size: 0 byte, 1 half, 2 32-bit, 3 full DATA_W.
load_signed  in  1  1 = sign-extend, 0 = zero-extend.
byte_off  in  log2(DATA_W/8)  byte offset of the load.
reg_wr_in  in  1  register write enable.
dir_wb_in  in  ADDR_W  destination register.
flush  in  1  synchronous pipeline flush.
out_valid  out  1  head entry valid.
out_ready  in  1  register file accepts the head entry.
reg_wr_out  out  1  out_valid AND head wr_en.
dir_wb_out  out  ADDR_W  head destination.
data_out  out  DATA_W  head data.
qry_addr  in  ADDR_W  forwarding query address.
qry_hit  out  1  a pending entry writes qry_addr.
qry_data  out  DATA_W  data of the youngest matching entry.
retire_cnt  out  CNT_W  completed output transfers.

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY, entries cleared, out_valid=0, reg_wr_out=0, dir_wb_out=0, data_out=0, retire_cnt=0, qry_hit=0. After reset, in_ready=1.
- Value selection is combinational on inputs and captured on accept (in_valid & in_ready). For MEM:
  - byte: lane byte_off.
  - half: lane pair byte_off[MSB:1]; byte_off[0] ignored.
  - 32-bit: word byte_off[MSB:2] (at DATA_W=32 equals size 3).
  - full: whole word.
  - The extracted field is sign- or zero-extended to DATA_W per load_signed.
  - load_size and load_signed are ignored for the other sources.
- Buffer FSM: EMPTY, ONE, FULL.
  - EMPTY + accept -> ONE.
  - ONE + accept without drain -> FULL.
  - ONE + drain without accept -> EMPTY.
  - ONE + accept + drain -> ONE; the new entry becomes the head.
  - FULL + drain -> ONE.
  - FULL never accepts.
- in_ready = (state != FULL), derived from registers only; no combinational out_ready -> in_ready path.
- Output is the head entry, registered, with latency 1 cycle from accept to out_valid. Drain = out_valid & out_ready.
- Output must hold stable while out_valid & !out_ready.
- Entries carry {wr_en, addr, data}. Entries with wr_en=0 still flow and still count toward retire_cnt.
- flush: next state EMPTY, and any beat presented in the same cycle is dropped. retire_cnt still counts a drain occurring in that cycle. flush has priority over accept.
- Forwarding query (combinational over valid entries with wr_en=1 and addr==qry_addr):
  - Youngest matching entry wins.
  - No match: qry_hit=0, qry_data=0.
  - In-flight input beats are not searched.
- retire_cnt increments by 1 per drain and wraps modulo 2^CNT_W.

Decomposition:
- Shared package wb_pkg:
  - sel_wb encodings: WB_SEL_ALU/MEM/LINK/IMM.
  - load_size encodings: LD_B/LD_H/LD_W/LD_D.
  - FSM state enum.
  - wb_entry_t struct.
- Sub-module wb_load_align: combinational lane extraction and extension.

Test Plan:
- Reset mid-traffic: assert rst_n=0 with FULL buffer -> out_valid=0, retire_cnt=0, in_ready=1 after release.
- MEM byte loads: result_mem=0x80FF7F01, byte_off=2, signed -> 0xFFFFFFFF; byte_off=3, signed -> 0xFFFFFF80; half, byte_off=2, unsigned -> 0x000080FF.
- Backpressure: out_ready=0, push 3 beats -> third beat refused (in_ready=0 after 2). Raise out_ready -> beats appear in order, data stable while stalled, retire_cnt=2.
- Streaming: in_valid=1 and out_ready=1 every cycle for 10 beats -> one beat out per cycle after 1-cycle latency, no bubbles, retire_cnt=10.
- Forwarding: pending r5=0x11 (older) and r5=0x22 (younger), qry_addr=5 -> qry_hit=1, qry_data=0x22. An entry with wr_en=0 to r5 does not hit.
- Flush + ZERO_REG_WR=0:
  - flush while FULL with a concurrent in_valid -> EMPTY next cycle, dropped beat never appears.
  - Write to r0 -> reg_wr_out=0 on drain.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the write-back stage buffer:
// source/load-size encodings, buffer state, entry bundle.
package wb_pkg;

  localparam int WB_DW_MAX = 64;
  localparam int WB_AW_MAX = 8;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'd0,
    WB_SEL_MEM  = 2'd1,
    WB_SEL_LINK = 2'd2,
    WB_SEL_IMM  = 2'd3
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

  // Sized for the widest legal configuration;
  // unused upper bits stay zero.
  typedef struct packed {
    logic                 wr_en;
    logic [WB_AW_MAX-1:0] addr;
    logic [WB_DW_MAX-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_stage_buf_if.sv
// MEM->WB input beat and WB->regfile output handshake.
// slave: buffer side; master: producer/consumer side.
interface wb_stage_buf_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  localparam int OFF_W = $clog2(DATA_W / 8)
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] result_alu;
  logic [DATA_W-1:0] result_mem;
  logic [DATA_W-1:0] result_link;
  logic [DATA_W-1:0] result_imm;
  logic [1:0]        sel_wb;
  logic [1:0]        load_size;
  logic              load_signed;
  logic [OFF_W-1:0]  byte_off;
  logic              reg_wr_in;
  logic [ADDR_W-1:0] dir_wb_in;
  logic              out_valid;
  logic              out_ready;
  logic              reg_wr_out;
  logic [ADDR_W-1:0] dir_wb_out;
  logic [DATA_W-1:0] data_out;

  modport slave (
    input  in_valid, result_alu, result_mem,
    input  result_link, result_imm, sel_wb,
    input  load_size, load_signed, byte_off,
    input  reg_wr_in, dir_wb_in, out_ready,
    output in_ready, out_valid, reg_wr_out,
    output dir_wb_out, data_out
  );

  modport master (
    output in_valid, result_alu, result_mem,
    output result_link, result_imm, sel_wb,
    output load_size, load_signed, byte_off,
    output reg_wr_in, dir_wb_in, out_ready,
    input  in_ready, out_valid, reg_wr_out,
    input  dir_wb_out, data_out
  );
endinterface

// File: rtl/wb_load_align.sv
// Load lane extraction + sign/zero extension.
// data_i raw word, size_i/signed_i/off_i select, data_o result.
module wb_load_align
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [OFF_W-1:0]  off_i,
  output logic [DATA_W-1:0] data_o
);

  // Halves and words are naturally aligned:
  // low offset bits are ignored.
  localparam logic [OFF_W-1:0] MASK_H = ~OFF_W'(1);
  localparam logic [OFF_W-1:0] MASK_W = ~OFF_W'(3);

  logic [DATA_W-1:0] sh_b, sh_h, sh_w;
  logic [7:0]        fb;
  logic [15:0]       fh;
  logic [31:0]       fw;

  assign sh_b = data_i >> {off_i, 3'b000};
  assign sh_h = data_i >> {off_i & MASK_H, 3'b000};
  assign sh_w = data_i >> {off_i & MASK_W, 3'b000};
  assign fb   = sh_b[7:0];
  assign fh   = sh_h[15:0];
  assign fw   = sh_w[31:0];

  always_comb begin
    data_o = data_i;
    unique case (1'b1)
      (size_i == LD_B):
        data_o = signed_i ? DATA_W'($signed(fb))
                          : DATA_W'(fb);
      (size_i == LD_H):
        data_o = signed_i ? DATA_W'($signed(fh))
                          : DATA_W'(fh);
      (size_i == LD_W):
        data_o = signed_i ? DATA_W'($signed(fw))
                          : DATA_W'(fw);
      (size_i == LD_D):
        data_o = data_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_buf.sv
// Write-back stage: source select, 2-entry skid buffer, forwarding query.
// bus: in/out handshake; flush; qry_addr/qry_hit/qry_data; retire_cnt.
module wb_stage_buf
  import wb_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 4,
  parameter int CNT_W       = 32,
  parameter bit ZERO_REG_WR = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_stage_buf_if.slave     bus,
  input  logic              flush,
  input  logic [ADDR_W-1:0] qry_addr,
  output logic              qry_hit,
  output logic [DATA_W-1:0] qry_data,
  output logic [CNT_W-1:0]  retire_cnt
);

  buf_state_e        state_q, state_d;
  wb_entry_t         head_q, head_d;
  wb_entry_t         tail_q, tail_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_val, sel_val;
  wb_entry_t         new_e;
  logic              accept, drain;
  logic              head_hit, tail_hit;

  wb_load_align #(.DATA_W(DATA_W)) u_align (
    .data_i   (bus.result_mem),
    .size_i   (bus.load_size),
    .signed_i (bus.load_signed),
    .off_i    (bus.byte_off),
    .data_o   (mem_val)
  );

  always_comb begin
    sel_val = bus.result_alu;
    unique case (1'b1)
      (bus.sel_wb == WB_SEL_ALU):  sel_val = bus.result_alu;
      (bus.sel_wb == WB_SEL_MEM):  sel_val = mem_val;
      (bus.sel_wb == WB_SEL_LINK): sel_val = bus.result_link;
      (bus.sel_wb == WB_SEL_IMM):  sel_val = bus.result_imm;
    endcase
  end

  // r0 writes are squashed here so every later
  // consumer (regfile, forwarding) sees wr_en=0.
  always_comb begin
    new_e       = '0;
    new_e.wr_en = bus.reg_wr_in &
                  (ZERO_REG_WR || (bus.dir_wb_in != '0));
    new_e.addr  = WB_AW_MAX'(bus.dir_wb_in);
    new_e.data  = WB_DW_MAX'(sel_val);
  end

  assign bus.in_ready   = (state_q != BUF_FULL);
  assign bus.out_valid  = (state_q != BUF_EMPTY);
  assign bus.reg_wr_out = bus.out_valid & head_q.wr_en;
  assign bus.dir_wb_out = head_q.addr[ADDR_W-1:0];
  assign bus.data_out   = head_q.data[DATA_W-1:0];
  assign accept = bus.in_valid & bus.in_ready;
  assign drain  = bus.out_valid & bus.out_ready;
  assign retire_cnt = cnt_q;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q + CNT_W'(drain);
    if (flush) begin
      state_d = BUF_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d = BUF_ONE;
            head_d  = new_e;
          end
        end
        BUF_ONE: begin
          if (accept && drain) begin
            head_d = new_e;
          end else if (accept) begin
            state_d = BUF_FULL;
            tail_d  = new_e;
          end else if (drain) begin
            state_d = BUF_EMPTY;
            head_d  = '0;
          end
        end
        BUF_FULL: begin
          if (drain) begin
            state_d = BUF_ONE;
            head_d  = tail_q;
            tail_d  = '0;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BUF_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tail is always younger than head.
  assign head_hit = (state_q != BUF_EMPTY) && head_q.wr_en &&
                    (head_q.addr == WB_AW_MAX'(qry_addr));
  assign tail_hit = (state_q == BUF_FULL) && tail_q.wr_en &&
                    (tail_q.addr == WB_AW_MAX'(qry_addr));

  always_comb begin
    qry_hit  = head_hit | tail_hit;
    qry_data = '0;
    if (tail_hit)
      qry_data = tail_q.data[DATA_W-1:0];
    else if (head_hit)
      qry_data = head_q.data[DATA_W-1:0];
  end

endmodule
